// File: rtl/audio_event_sequencer.sv
// Audio clip sequencer: latches event requests, grants the highest-index one,
// and steps through START, PLAY and GAP while the player runs the clip.
module audio_event_sequencer #(
    parameter int unsigned NUM_EVT     = 6,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_EVT-1:0] evt_req_i,
    input  logic               mute_i,
    input  logic               abort_i,
    input  logic               seq_end_i,
    output logic               audio_en_o,
    output logic [SEL_W-1:0]   audio_sel_o,
    output logic               busy_o,
    output logic [1:0]         state_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [7:0]         drop_cnt_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StPlay  = 2'd2;
    localparam logic [1:0] StGap   = 2'd3;

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GapLast   = GW'(GAP_CYC - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_EVT-1:0] pend_q, pend_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               to_q, to_d;
    logic [7:0]         drop_q, drop_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [GW-1:0]      gap_q, gap_d;

    logic [SEL_W-1:0]   win_idx;
    logic               start_go;
    logic [NUM_EVT-1:0] grant_mask;
    logic [NUM_EVT-1:0] req_set;
    logic               dup;

    // Later indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (pend_q[i]) begin
                win_idx = SEL_W'(i);
            end
        end
    end

    assign start_go   = (state_q == StIdle) && (pend_q != '0) && !abort_i;
    assign grant_mask = start_go ? (NUM_EVT'(1) << win_idx) : '0;
    assign req_set    = mute_i ? '0 : evt_req_i;
    assign dup        = |(req_set & pend_q & ~grant_mask);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        to_d    = 1'b0;
        timer_d = timer_q;
        gap_d   = gap_q;
        // Re-setting a bit on its own grant edge keeps it pending; abort beats both.
        pend_d  = abort_i ? '0 : ((pend_q & ~grant_mask) | req_set);
        drop_d  = (dup && (drop_q != 8'hff)) ? drop_q + 8'd1 : drop_q;

        case (state_q)
            StIdle: begin
                if (start_go) begin
                    state_d = StStart;
                    sel_d   = win_idx + SEL_W'(1);
                    en_d    = 1'b1;
                end
            end
            StStart: begin
                if (abort_i) begin
                    state_d = StGap;
                    sel_d   = '0;
                    gap_d   = '0;
                end else begin
                    state_d = StPlay;
                    timer_d = '0;
                end
            end
            StPlay: begin
                timer_d = timer_q + TW'(1);
                // A seq_end seen at timer 0 is a stale level from the previous clip.
                if (abort_i) begin
                    state_d = StGap;
                    sel_d   = '0;
                    gap_d   = '0;
                end else if (seq_end_i && (timer_q != '0)) begin
                    state_d = StGap;
                    sel_d   = '0;
                    gap_d   = '0;
                    done_d  = 1'b1;
                end else if (timer_q == TimerLast) begin
                    state_d = StGap;
                    sel_d   = '0;
                    gap_d   = '0;
                    to_d    = 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pend_q  <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            drop_q  <= '0;
            timer_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            done_q  <= done_d;
            to_q    <= to_d;
            drop_q  <= drop_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
        end
    end

    assign audio_en_o  = en_q;
    assign audio_sel_o = sel_q;
    assign busy_o      = (state_q != StIdle);
    assign state_o     = state_q;
    assign done_o      = done_q;
    assign timeout_o   = to_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_audio_event_sequencer.sv
// Bench for audio_event_sequencer: scenario tasks plus a scoreboard of expected
// clip starts and clip-end kinds checked as the DUT emits them.
module tb_audio_event_sequencer;

    logic       clk;
    logic       rst_ni;
    logic [5:0] evt_req;
    logic       mute;
    logic       abort;
    logic       seq_end;
    logic       audio_en;
    logic [2:0] audio_sel;
    logic       busy;
    logic [1:0] state;
    logic       done;
    logic       timeout;
    logic [7:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] exp_sel_q[$];
    logic [1:0] exp_end_q[$];
    logic [2:0] sb_sel;
    logic [1:0] sb_end;

    audio_event_sequencer #(
        .NUM_EVT    (6),
        .SEL_W      (3),
        .GAP_CYC    (4),
        .TIMEOUT_CYC(1000)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .evt_req_i  (evt_req),
        .mute_i     (mute),
        .abort_i    (abort),
        .seq_end_i  (seq_end),
        .audio_en_o (audio_en),
        .audio_sel_o(audio_sel),
        .busy_o     (busy),
        .state_o    (state),
        .done_o     (done),
        .timeout_o  (timeout),
        .drop_cnt_o (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: end codes are {timeout, done}.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (audio_en) begin
                vectors++;
                if (exp_sel_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_start: unexpected start, sel got %0d want none", audio_sel);
                end else begin
                    sb_sel = exp_sel_q.pop_front();
                    if (audio_sel !== sb_sel) begin
                        miscompares++;
                        $display("FAIL sb_start_sel: got %0d want %0d", audio_sel, sb_sel);
                    end
                end
            end
            if (done || timeout) begin
                vectors++;
                if (exp_end_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_end: unexpected end pulse {to,done} got %b want none",
                             {timeout, done});
                end else begin
                    sb_end = exp_end_q.pop_front();
                    if ({timeout, done} !== sb_end) begin
                        miscompares++;
                        $display("FAIL sb_end_kind: {to,done} got %b want %b",
                                 {timeout, done}, sb_end);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_ni  = 1'b0;
        evt_req = '0;
        mute    = 1'b0;
        abort   = 1'b0;
        seq_end = 1'b0;
        tick(2);
        vectors++;
        if ({audio_en, audio_sel, busy, state, done, timeout, drop_cnt} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0000",
                     {audio_en, audio_sel, busy, state, done, timeout, drop_cnt});
        end
        rst_ni = 1'b1;
        tick(2);
        vectors++;
        if (state !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: state got %0d want 0", state);
        end
    endtask

    task automatic test_single;
        evt_req = 6'b000100;
        exp_sel_q.push_back(3'd3);
        exp_end_q.push_back(2'b01);
        tick(1);
        evt_req = '0;
        vectors++;
        if (audio_en !== 1'b0 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL single_n1: en got %b state got %0d want 0/0", audio_en, state);
        end
        tick(1);
        vectors++;
        if (audio_en !== 1'b1 || audio_sel !== 3'd3 || state !== 2'd1) begin
            miscompares++;
            $display("FAIL single_n2: en/sel/state got %b/%0d/%0d want 1/3/1",
                     audio_en, audio_sel, state);
        end
        tick(1);
        vectors++;
        if (state !== 2'd2 || audio_en !== 1'b0 || audio_sel !== 3'd3) begin
            miscompares++;
            $display("FAIL single_play: en/sel/state got %b/%0d/%0d want 0/3/2",
                     audio_en, audio_sel, state);
        end
        tick(7);
        seq_end = 1'b1;
        tick(1);
        seq_end = 1'b0;
        vectors++;
        if (done !== 1'b1 || state !== 2'd3 || audio_sel !== 3'd0) begin
            miscompares++;
            $display("FAIL single_done: done/state/sel got %b/%0d/%0d want 1/3/0",
                     done, state, audio_sel);
        end
        tick(3);
        vectors++;
        if (state !== 2'd3) begin
            miscompares++;
            $display("FAIL single_gap_len: state got %0d want 3", state);
        end
        tick(1);
        vectors++;
        if (state !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: state/busy got %0d/%b want 0/0", state, busy);
        end
    endtask

    task automatic test_priority;
        evt_req = 6'b100001;
        exp_sel_q.push_back(3'd6);
        exp_sel_q.push_back(3'd1);
        exp_end_q.push_back(2'b01);
        exp_end_q.push_back(2'b01);
        tick(1);
        evt_req = '0;
        tick(1);
        vectors++;
        if (audio_sel !== 3'd6) begin
            miscompares++;
            $display("FAIL prio_first: sel got %0d want 6", audio_sel);
        end
        tick(3);
        seq_end = 1'b1;
        tick(1);
        seq_end = 1'b0;
        tick(4);
        vectors++;
        if (state !== 2'd0) begin
            miscompares++;
            $display("FAIL prio_idle_between: state got %0d want 0", state);
        end
        tick(1);
        vectors++;
        if (audio_en !== 1'b1 || audio_sel !== 3'd1) begin
            miscompares++;
            $display("FAIL prio_second: en/sel got %b/%0d want 1/1", audio_en, audio_sel);
        end
        // seq_end during the timer==0 PLAY cycle must be ignored.
        tick(1);
        seq_end = 1'b1;
        tick(1);
        vectors++;
        if (state !== 2'd2 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_stale_end: state/done got %0d/%b want 2/0", state, done);
        end
        tick(1);
        seq_end = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_second_done: done got %b want 1", done);
        end
        tick(4);
        vectors++;
        if (drop_cnt !== 8'd0 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL prio_drop: drop/state got %0d/%0d want 0/0", drop_cnt, state);
        end
    endtask

    task automatic test_timeout;
        evt_req = 6'b000010;
        exp_sel_q.push_back(3'd2);
        exp_end_q.push_back(2'b10);
        tick(1);
        evt_req = '0;
        tick(1);
        tick(1000);
        vectors++;
        if (state !== 2'd2 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL to_before: state/to got %0d/%b want 2/0", state, timeout);
        end
        tick(1);
        vectors++;
        if (timeout !== 1'b1 || done !== 1'b0 || state !== 2'd3) begin
            miscompares++;
            $display("FAIL to_pulse: to/done/state got %b/%b/%0d want 1/0/3",
                     timeout, done, state);
        end
        tick(4);
        evt_req = 6'b000010;
        exp_sel_q.push_back(3'd2);
        exp_end_q.push_back(2'b01);
        tick(1);
        evt_req = '0;
        tick(1);
        tick(1000);
        seq_end = 1'b1;
        tick(1);
        seq_end = 1'b0;
        vectors++;
        if (done !== 1'b1 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL to_race: done/to got %b/%b want 1/0", done, timeout);
        end
        tick(4);
    endtask

    task automatic test_back_to_back;
        evt_req = 6'b010000;
        exp_sel_q.push_back(3'd5);
        exp_sel_q.push_back(3'd5);
        exp_end_q.push_back(2'b01);
        exp_end_q.push_back(2'b01);
        tick(1);
        tick(1);
        evt_req = '0;
        tick(2);
        seq_end = 1'b1;
        tick(1);
        seq_end = 1'b0;
        tick(5);
        vectors++;
        if (audio_en !== 1'b1 || audio_sel !== 3'd5) begin
            miscompares++;
            $display("FAIL b2b_regrant: en/sel got %b/%0d want 1/5", audio_en, audio_sel);
        end
        tick(2);
        seq_end = 1'b1;
        tick(1);
        seq_end = 1'b0;
        tick(4);
        vectors++;
        if (drop_cnt !== 8'd0 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL b2b_drop: drop/state got %0d/%0d want 0/0", drop_cnt, state);
        end
    endtask

    task automatic test_coalesce;
        evt_req = 6'b000001;
        exp_sel_q.push_back(3'd1);
        exp_end_q.push_back(2'b01);
        tick(1);
        evt_req = '0;
        tick(2);
        evt_req = 6'b000100;
        tick(4);
        mute    = 1'b1;
        evt_req = 6'b001100;
        tick(1);
        mute    = 1'b0;
        evt_req = '0;
        vectors++;
        if (drop_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL coal_drop3: got %0d want 3", drop_cnt);
        end
        seq_end = 1'b1;
        exp_sel_q.push_back(3'd3);
        exp_end_q.push_back(2'b01);
        tick(1);
        seq_end = 1'b0;
        tick(5);
        vectors++;
        if (audio_sel !== 3'd3 || state !== 2'd1) begin
            miscompares++;
            $display("FAIL coal_next: sel/state got %0d/%0d want 3/1", audio_sel, state);
        end
        tick(2);
        seq_end = 1'b1;
        tick(1);
        seq_end = 1'b0;
        tick(6);
        vectors++;
        if (state !== 2'd0) begin
            miscompares++;
            $display("FAIL mute_ignored: state got %0d want 0", state);
        end
        // Saturation: hold bit 2 pending under a running clip for 300 duplicate cycles.
        evt_req = 6'b000001;
        exp_sel_q.push_back(3'd1);
        exp_end_q.push_back(2'b01);
        tick(1);
        evt_req = '0;
        tick(2);
        evt_req = 6'b000100;
        tick(301);
        evt_req = '0;
        vectors++;
        if (drop_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_drop: got %0d want 255", drop_cnt);
        end
        seq_end = 1'b1;
        exp_sel_q.push_back(3'd3);
        exp_end_q.push_back(2'b01);
        tick(1);
        seq_end = 1'b0;
        tick(7);
        seq_end = 1'b1;
        tick(1);
        seq_end = 1'b0;
        tick(5);
    endtask

    task automatic test_abort;
        evt_req = 6'b000010;
        exp_sel_q.push_back(3'd2);
        tick(1);
        evt_req = 6'b010001;
        tick(1);
        evt_req = '0;
        tick(3);
        abort   = 1'b1;
        evt_req = 6'b001000;
        tick(1);
        abort   = 1'b0;
        evt_req = '0;
        vectors++;
        if (state !== 2'd3 || done !== 1'b0 || timeout !== 1'b0 || audio_sel !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_play: state/done/to/sel got %0d/%b/%b/%0d want 3/0/0/0",
                     state, done, timeout, audio_sel);
        end
        tick(6);
        vectors++;
        if (state !== 2'd0) begin
            miscompares++;
            $display("FAIL abort_flush: state got %0d want 0", state);
        end
        evt_req = 6'b000001;
        tick(1);
        evt_req = '0;
        abort   = 1'b1;
        tick(1);
        abort   = 1'b0;
        tick(2);
        vectors++;
        if (state !== 2'd0 || audio_en !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: state/en got %0d/%b want 0/0", state, audio_en);
        end
    endtask

    task automatic test_reset_mid;
        evt_req = 6'b000100;
        exp_sel_q.push_back(3'd3);
        tick(1);
        evt_req = 6'b100000;
        tick(1);
        evt_req = '0;
        tick(2);
        #2;
        rst_ni = 1'b0;
        #1;
        vectors++;
        if ({audio_en, audio_sel, busy, state, done, timeout, drop_cnt} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_async: got %h want 0000",
                     {audio_en, audio_sel, busy, state, done, timeout, drop_cnt});
        end
        tick(2);
        rst_ni = 1'b1;
        tick(4);
        vectors++;
        if (state !== 2'd0 || audio_en !== 1'b0 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_flush: state/en/drop got %0d/%b/%0d want 0/0/0",
                     state, audio_en, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_timeout();
        test_back_to_back();
        test_coalesce();
        test_abort();
        test_reset_mid();
        tick(2);
        vectors++;
        if (exp_sel_q.size() != 0 || exp_end_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: leftover starts/ends got %0d/%0d want 0/0",
                     exp_sel_q.size(), exp_end_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_event_sequencer.md
AUDIO_EVENT_SEQUENCER -- requirements
Module: audio_event_sequencer

Interface
REQ-001 Parameter NUM_EVT, 6, number of event request channels (1..15).
REQ-002 Parameter SEL_W, 3, width of audio_sel; SHALL satisfy 2^SEL_W > NUM_EVT.
REQ-003 Parameter GAP_CYC, 4, silent cycles between clips (>=1).
REQ-004 Parameter TIMEOUT_CYC, 1000, maximum PLAY cycles before forced end (>=2).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 evt_req  in  NUM_EVT  one-cycle request pulses; bit i requests clip i+1.
REQ-008 mute  in  1  level; while 1, new requests are ignored.
REQ-009 abort  in  1  one-cycle pulse; flushes pending requests and ends the current clip.
REQ-010 seq_end  in  1  clip-finished indication from the audio player.
REQ-011 audio_en  out  1  one-cycle start pulse to the audio player.
REQ-012 audio_sel  out  SEL_W  clip select to the audio player; 0 = silence.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 state  out  2  IDLE=0, START=1, PLAY=2, GAP=3.
REQ-015 done  out  1  one-cycle pulse; clip ended by seq_end.
REQ-016 timeout  out  1  one-cycle pulse; clip ended by the timeout.
REQ-017 drop_cnt  out  8  saturating count of coalesced duplicate requests.

Function
REQ-018 Pending mask, NUM_EVT bits: bit i set at the edge where evt_req[i]=1 and mute=0.
REQ-019 Grant: highest-index set pending bit wins; its bit clears on the IDLE->START edge.
REQ-020 Same-cycle grant and new request on the same bit: the set wins and the bit stays pending.
REQ-021 Request on an already-pending bit (not its grant cycle): drop_cnt +1 per such cycle, saturating at 255.
REQ-022 IDLE: pending!=0 -> START and audio_sel <= winner+1; otherwise hold.
REQ-023 START lasts exactly 1 cycle with audio_en=1, then -> PLAY with the PLAY timer cleared to 0.
REQ-024 Latency: evt_req in cycle N, while idle with empty pending mask -> audio_en=1 in cycle N+2.
REQ-025 PLAY: the timer increments each cycle; seq_end is ignored while timer==0, to skip stale levels.
REQ-026 PLAY: seq_end=1 with timer>=1 -> GAP, with done=1 for the first GAP cycle.
REQ-027 PLAY: timer==TIMEOUT_CYC-1 with no valid seq_end -> GAP, with timeout=1 for the first GAP cycle.
REQ-028 seq_end and timeout in the same cycle: seq_end wins; done only.
REQ-029 audio_sel holds its value in START and PLAY; it is 0 in IDLE and GAP.
REQ-030 GAP: count GAP_CYC cycles, then -> IDLE; requests keep accumulating during GAP.
REQ-031 abort: clears the whole pending mask in the same edge, overriding any same-cycle set.
REQ-032 abort in START or PLAY -> GAP; no done or timeout pulse.
REQ-033 abort in IDLE or GAP: no state change.
REQ-034 mute does not affect a clip in progress or bits already pending.
REQ-035 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-036 rst=0 forces, asynchronously, state=IDLE, pending=0, audio_sel=0, audio_en=0, done=0, timeout=0, drop_cnt=0, timers=0.
REQ-037 Reset mid-clip discards the clip and all pending requests; no pulse is generated.
REQ-038 Reset release is sampled synchronously; the first active edge follows the IDLE rules.

Verification (NUM_EVT=6, GAP_CYC=4, TIMEOUT_CYC=1000)
REQ-039 Single request: evt_req=6'b000100 in cycle 10 -> audio_en=1 and audio_sel=3 in cycle 12.
  Then seq_end in cycle 20 -> done in cycle 21, IDLE in cycle 25.
REQ-040 Priority: evt_req=6'b100001 in one cycle -> clip 6 plays first.
  Clip 1 starts 2 cycles after GAP ends.
  drop_cnt stays 0.
REQ-041 Timeout: no seq_end -> timeout pulse 1001 cycles after the START cycle, done stays 0.
  seq_end and the timeout limit in the same cycle -> done only.
REQ-042 Coalescing, mute, saturation: bit 2 requested 3 times while pending -> drop_cnt=3.
  Requests under mute=1 are not recorded.
  300 duplicates -> drop_cnt=255.
REQ-043 Abort and reset: abort in PLAY with bits 0 and 4 pending -> GAP, pending=0, no done.
  rst=0 mid-PLAY -> all outputs 0 immediately, without waiting for a clock edge.
